// File: rtl/sample_avg_ctrl.sv
// ---------------------------------------------------------------------------
// sample_avg_ctrl
//   Accumulates an unsigned sample stream into a saturating sum and a count.
//   A window closes automatically after MAX_CNT samples or early on flush.
//   The controller then hands sum/count to an external divider and reports
//   the quotient as the window average.
//
//   Optional feature: define AVG_TIMEOUT_EN to add a divider watchdog. If the
//   divider stays silent for TIMEOUT cycles in WAIT, the window is reported
//   with avg_err=1.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   s_valid/s_ready : sample handshake, s_data is the sample
//   flush           : close the current window early (ACCUM only)
//   div_start       : one-cycle start pulse to the divider
//   div_a, div_b    : dividend (sum) and divisor (count), held until EMIT
//   div_busy        : divider cannot accept a start
//   div_done        : divider result strobe with div_val/valid/dbz/ovf
//   avg_valid       : one-cycle result pulse
//   avg_data        : average (0 when avg_err)
//   avg_err         : divide-by-zero, overflow, saturation or invalid result
//   avg_count       : number of samples in the reported window
//   dbg_state       : current FSM state (ACCUM=0, LAUNCH=1, WAIT=2, EMIT=3)
//
// Handshake: a sample transfers on a rising edge where s_valid && s_ready;
// s_ready depends only on state, never on s_valid.
// ---------------------------------------------------------------------------
module sample_avg_ctrl #(
   parameter int WIDTH    = 24,
   parameter int SAMPLE_W = 16,
   parameter int MAX_CNT  = 255,
   parameter int TIMEOUT  = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                s_ready,
   input  logic                flush,
   output logic                div_start,
   output logic [WIDTH-1:0]    div_a,
   output logic [WIDTH-1:0]    div_b,
   input  logic                div_busy,
   input  logic                div_done,
   input  logic                div_valid,
   input  logic                div_dbz,
   input  logic                div_ovf,
   input  logic [WIDTH-1:0]    div_val,
   output logic                avg_valid,
   output logic [WIDTH-1:0]    avg_data,
   output logic                avg_err,
   output logic [15:0]         avg_count,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_EMIT   = 2'd3
   } state_t;

   localparam logic [15:0] MAX_CNT_L = 16'(MAX_CNT);

   state_t             state_q;
   logic [WIDTH-1:0]   sum_q;
   logic [15:0]        cnt_q;
   logic               sat_q;
   logic               div_start_q;
   logic [WIDTH-1:0]   div_a_q;
   logic [WIDTH-1:0]   div_b_q;
   logic               avg_valid_q;
   logic [WIDTH-1:0]   avg_data_q;
   logic               avg_err_q;
   logic [15:0]        avg_count_q;

`ifdef AVG_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   logic [TMO_W-1:0]   tmo_q;
`endif

   // Accumulator next-state for the current ACCUM cycle.
   logic               xfer;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH-1:0]   sum_d;
   logic [15:0]        cnt_d;
   logic               sat_d;
   logic               close_win;
   logic               res_err;

   assign xfer    = s_valid && (state_q == ST_ACCUM);
   assign sum_ext = {1'b0, sum_q} + {{(WIDTH + 1 - SAMPLE_W){1'b0}}, s_data};

   always_comb begin
      sum_d = sum_q;
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (xfer) begin
         // Carry out of the WIDTH-bit sum means the true total no longer fits.
         if (sum_ext[WIDTH]) begin
            sum_d = '1;
            sat_d = 1'b1;
         end else begin
            sum_d = sum_ext[WIDTH-1:0];
         end
         cnt_d = cnt_q + 16'd1;
      end
   end

   // A sample arriving together with flush belongs to the closing window.
   assign close_win = (state_q == ST_ACCUM) &&
                      ((xfer && (cnt_d == MAX_CNT_L)) || flush);

   assign res_err = div_dbz || div_ovf || sat_q || !div_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         sum_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         div_start_q <= 1'b0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         avg_valid_q <= 1'b0;
         avg_data_q  <= '0;
         avg_err_q   <= 1'b0;
         avg_count_q <= '0;
`ifdef AVG_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         case (state_q)
            ST_ACCUM: begin
               sum_q <= sum_d;
               cnt_q <= cnt_d;
               sat_q <= sat_d;
               if (close_win) begin
                  // Operands are frozen here and held until the next launch.
                  div_a_q <= sum_d;
                  div_b_q <= WIDTH'(cnt_d);
                  state_q <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               if (!div_busy) begin
                  div_start_q <= 1'b1;
                  state_q     <= ST_WAIT;
`ifdef AVG_TIMEOUT_EN
                  tmo_q       <= '0;
`endif
               end
            end
            ST_WAIT: begin
               div_start_q <= 1'b0;
               if (div_done) begin
                  avg_valid_q <= 1'b1;
                  avg_err_q   <= res_err;
                  avg_data_q  <= res_err ? '0 : div_val;
                  avg_count_q <= cnt_q;
                  state_q     <= ST_EMIT;
               end
`ifdef AVG_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  avg_valid_q <= 1'b1;
                  avg_err_q   <= 1'b1;
                  avg_data_q  <= '0;
                  avg_count_q <= cnt_q;
                  state_q     <= ST_EMIT;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            ST_EMIT: begin
               avg_valid_q <= 1'b0;
               sum_q       <= '0;
               cnt_q       <= '0;
               sat_q       <= 1'b0;
               state_q     <= ST_ACCUM;
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

   assign s_ready   = (state_q == ST_ACCUM);
   assign div_start = div_start_q;
   assign div_a     = div_a_q;
   assign div_b     = div_b_q;
   assign avg_valid = avg_valid_q;
   assign avg_data  = avg_data_q;
   assign avg_err   = avg_err_q;
   assign avg_count = avg_count_q;
   assign dbg_state = state_q;

endmodule

// File: doc/sample_avg_ctrl.md
SAMPLE_AVG_CTRL -- requirements
Module: sample_avg_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning divider operand/result width (bits).
REQ-002 SHALL have parameter SAMPLE_W, default 16, meaning input sample width (unsigned), SAMPLE_W < WIDTH.
REQ-003 SHALL have parameter MAX_CNT, default 255, meaning samples per automatic average window, 1..2^16-1.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning divider watchdog limit in cycles (used only under AVG_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have ports s_valid input 1, s_data input SAMPLE_W, s_ready output 1: sample stream, transfer when s_valid && s_ready.
REQ-008 SHALL have port flush  input  1  request to close the current window early.
REQ-009 SHALL have ports div_start output 1, div_a output WIDTH (dividend), div_b output WIDTH (divisor) to the divider.
REQ-010 SHALL have ports div_busy, div_done, div_valid, div_dbz, div_ovf input 1 each, and div_val input WIDTH, from the divider.
REQ-011 SHALL have ports avg_valid output 1, avg_data output WIDTH, avg_err output 1, avg_count output 16 (samples in the reported window).

Function
REQ-012 SHALL implement states ACCUM, LAUNCH, WAIT, EMIT; reset state ACCUM.
REQ-013 SHALL assert s_ready only in ACCUM.
REQ-014 In ACCUM, each transfer SHALL add s_data (zero-extended) to a WIDTH-bit sum and increment a 16-bit count.
REQ-015 Sum addition SHALL saturate at 2^WIDTH-1 and set a sticky sat flag cleared at window start.
REQ-016 ACCUM SHALL move to LAUNCH on the cycle after the transfer making count == MAX_CNT, or on the cycle after flush is sampled high.
REQ-017 A transfer and flush in the same cycle SHALL include the sample in the closing window.
REQ-018 flush with count == 0 SHALL still launch, divisor 0.
REQ-019 LAUNCH SHALL hold div_a = sum and div_b = count zero-extended, pulse div_start high exactly one cycle, then enter WAIT; div_a/div_b SHALL stay stable until EMIT.
REQ-020 LAUNCH SHALL wait with div_start low while div_busy is high.
REQ-021 WAIT SHALL enter EMIT on the cycle after div_done is sampled high, capturing div_val, div_valid, div_dbz, div_ovf.
REQ-022 EMIT SHALL pulse avg_valid one cycle with avg_data = captured div_val, avg_count = window count, avg_err = dbz || ovf || sat || !div_valid.
REQ-023 When avg_err is 1, avg_data SHALL be 0.
REQ-024 EMIT SHALL clear sum, count, sat and return to ACCUM; flush during LAUNCH/WAIT/EMIT SHALL be ignored.
REQ-025 Latency from window close to avg_valid SHALL be divider latency + 3 cycles.

Reset
REQ-026 rst high SHALL, on the next edge, force state ACCUM, clear sum, count, sat, capture registers, and drive s_ready=1, div_start=0, div_a=0, div_b=0, avg_valid=0, avg_data=0, avg_err=0, avg_count=0.
REQ-027 rst during LAUNCH/WAIT SHALL abandon the window with no avg_valid pulse; a later div_done SHALL be ignored in ACCUM.

Configuration
REQ-028 Macro AVG_TIMEOUT_EN defined SHALL add a WAIT-state cycle counter; reaching TIMEOUT without div_done SHALL enter EMIT with avg_err=1, avg_data=0.
REQ-029 Without AVG_TIMEOUT_EN, WAIT SHALL wait for div_done indefinitely and the counter SHALL not exist.

Verification
REQ-030 MAX_CNT=4, samples 10,20,30,40 -> one div_start with div_a=100, div_b=4; divider returns 25 -> avg_valid, avg_data=25, avg_count=4, avg_err=0.
REQ-031 Samples 7,9 then flush coincident with third sample 11 -> div_a=27, div_b=3, avg_count=3.
REQ-032 flush with no samples -> div_b=0; divider dbz=1 -> avg_err=1, avg_data=0, avg_count=0.
REQ-033 WIDTH=24, SAMPLE_W=16, MAX_CNT=300 of 0xFFFF -> sum saturates at 0xFFFFFF, avg_err=1.
REQ-034 rst pulsed in WAIT, div_done arrives 2 cycles later -> no avg_valid, s_ready=1, next window starts from count 0.
REQ-035 AVG_TIMEOUT_EN, TIMEOUT=16, divider never asserts done -> avg_valid with avg_err=1 exactly 16 cycles after WAIT entry + 1; without macro, state stays WAIT.
